// File: rtl/lane_seq_pkg.sv
// Shared types and constants for the lane op sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package lane_seq_pkg;

  localparam int         LANES    = 6;
  localparam logic [3:0] LAST_IDX = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam logic [1:0] MODE_VV    = 2'b00;
  localparam logic [1:0] MODE_VE    = 2'b01;
  localparam logic [1:0] MODE_VI    = 2'b10;
  localparam logic [1:0] MODE_SWEEP = 2'b11;

  localparam logic [1:0] VSI_VEC  = 2'b00;
  localparam logic [1:0] VSI_ELEM = 2'b01;
  localparam logic [1:0] VSI_IMM  = 2'b10;

  // Sweep broadcasts one element of B per beat, so it shares the element path.
  function automatic logic [1:0] vsi_for_mode(input logic [1:0] mode);
    case (mode)
      MODE_VE:    return VSI_ELEM;
      MODE_VI:    return VSI_IMM;
      MODE_SWEEP: return VSI_ELEM;
      default:    return VSI_VEC;
    endcase
  endfunction

endpackage

// File: rtl/lane_seq_result_reg.sv
// Result beat register: holds captured lane data, flags, element index, last and error.
// Latency: loaded/cleared on the clock edge where load_i/clear_i is high.
// Backpressure: contents are held unchanged while neither control is asserted.
module lane_seq_result_reg
  import lane_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 clear_i,
  input  logic [LANES*N-1:0]   data_i,
  input  logic [2*LANES-1:0]   flags_i,
  input  logic [3:0]           idx_i,
  input  logic                 last_i,
  input  logic                 err_i,
  output logic [LANES*N-1:0]   data_o,
  output logic [2*LANES-1:0]   flags_o,
  output logic [3:0]           idx_o,
  output logic                 last_o,
  output logic                 err_o
);

  logic [LANES*N-1:0] data_q;
  logic [2*LANES-1:0] flags_q;
  logic [3:0]         idx_q;
  logic               last_q;
  logic               err_q;

  // Clear wins over load so a retired beat never leaves stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      flags_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (clear_i) begin
      data_q  <= '0;
      flags_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      flags_q <= flags_i;
      idx_q   <= idx_i;
      last_q  <= last_i;
      err_q   <= err_i;
    end
  end

  assign data_o  = data_q;
  assign flags_o = flags_q;
  assign idx_o   = idx_q;
  assign last_o  = last_q;
  assign err_o   = err_q;

endmodule

// File: rtl/lane_op_sequencer.sv
// Issue controller for the 6-lane vector ALU array; sweep mode yields six beats per command.
// Latency: accept edge -> res_valid after 2 edges (1 edge for a rejected element index).
// Backpressure: OUT holds the beat until res_ready; req_ready is low outside IDLE.
module lane_op_sequencer
  import lane_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [1:0]           req_mode,
  input  logic [3:0]           req_idx,
  input  logic [N-1:0]         req_imm,
  output logic [2:0]           ALUControlE,
  output logic [1:0]           VSIFlagE,
  output logic [3:0]           SrcBiE,
  output logic [N-1:0]         ImmE,
  output logic                 alu_issue,
  input  logic [LANES*N-1:0]   ALUOutputE,
  input  logic [2*LANES-1:0]   ALUFlagsE,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [LANES*N-1:0]   res_data,
  output logic [2*LANES-1:0]   res_flags,
  output logic [3:0]           res_idx,
  output logic                 res_last,
  output logic                 res_err
);

  state_e       state_q, state_d;
  logic [3:0]   step_q, step_d;
  logic [2:0]   op_q;
  logic [1:0]   mode_q;
  logic [3:0]   idx_q;
  logic [N-1:0] imm_q;
  logic         accept;

  logic               rr_load, rr_clear, rr_last, rr_err;
  logic [LANES*N-1:0] rr_data;
  logic [2*LANES-1:0] rr_flags;
  logic [3:0]         rr_idx;

  // State, sweep step and the command captured at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      op_q    <= '0;
      mode_q  <= '0;
      idx_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (accept) begin
        op_q   <= req_op;
        mode_q <= req_mode;
        idx_q  <= req_idx;
        imm_q  <= req_imm;
      end
    end
  end

  // Next state, ALU drive during ISSUE, and what the result register loads.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    req_ready   = 1'b0;
    res_valid   = 1'b0;
    alu_issue   = 1'b0;
    ALUControlE = '0;
    VSIFlagE    = '0;
    SrcBiE      = '0;
    ImmE        = '0;
    accept      = 1'b0;
    rr_load     = 1'b0;
    rr_clear    = 1'b0;
    rr_data     = '0;
    rr_flags    = '0;
    rr_idx      = '0;
    rr_last     = 1'b0;
    rr_err      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          step_d = '0;
          if (req_mode == MODE_VE && req_idx > LAST_IDX) begin
            // Out-of-range element: answer with an error beat, never touch the ALU.
            rr_load = 1'b1;
            rr_idx  = req_idx;
            rr_last = 1'b1;
            rr_err  = 1'b1;
            state_d = OUT;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        alu_issue   = 1'b1;
        ALUControlE = op_q;
        VSIFlagE    = vsi_for_mode(mode_q);
        case (mode_q)
          MODE_VE:    SrcBiE = idx_q;
          MODE_SWEEP: SrcBiE = step_q;
          default:    SrcBiE = '0;
        endcase
        ImmE     = (mode_q == MODE_VI) ? imm_q : '0;
        rr_load  = 1'b1;
        rr_data  = ALUOutputE;
        rr_flags = ALUFlagsE;
        rr_idx   = SrcBiE;
        rr_last  = (mode_q != MODE_SWEEP) || (step_q == LAST_IDX);
        state_d  = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (res_last) begin
            rr_clear = 1'b1;
            state_d  = IDLE;
          end else begin
            step_d  = (step_q == LAST_IDX) ? step_q : step_q + 4'd1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  lane_seq_result_reg #(.N(N)) u_result (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (rr_load),
    .clear_i (rr_clear),
    .data_i  (rr_data),
    .flags_i (rr_flags),
    .idx_i   (rr_idx),
    .last_i  (rr_last),
    .err_i   (rr_err),
    .data_o  (res_data),
    .flags_o (res_flags),
    .idx_o   (res_idx),
    .last_o  (res_last),
    .err_o   (res_err)
  );

endmodule

// File: tb/tb_lane_op_sequencer.sv
// Bench for lane_op_sequencer with a behavioural ALU array and a beat scoreboard.
// Latency: n/a.
// Backpressure: res_ready is driven from the stimulus process.
module tb_lane_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [1:0]  req_mode;
  logic [3:0]  req_idx;
  logic [7:0]  req_imm;
  logic [2:0]  ALUControlE;
  logic [1:0]  VSIFlagE;
  logic [3:0]  SrcBiE;
  logic [7:0]  ImmE;
  logic        alu_issue;
  logic [47:0] ALUOutputE;
  logic [11:0] ALUFlagsE;
  logic        res_valid, res_ready;
  logic [47:0] res_data;
  logic [11:0] res_flags;
  logic [3:0]  res_idx;
  logic        res_last, res_err;

  lane_op_sequencer #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_mode(req_mode),
    .req_idx(req_idx), .req_imm(req_imm),
    .ALUControlE(ALUControlE), .VSIFlagE(VSIFlagE), .SrcBiE(SrcBiE), .ImmE(ImmE),
    .alu_issue(alu_issue), .ALUOutputE(ALUOutputE), .ALUFlagsE(ALUFlagsE),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .res_idx(res_idx), .res_last(res_last), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [47:0] d;
    logic [11:0] f;
    logic [3:0]  i;
    logic        l;
    logic        e;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  // Behavioural ALU array: op 0 ADD, 1 SUB, 2 AND; flags per lane are {carry, zero}.
  logic [7:0] a_lane [6];
  logic [7:0] b_lane [6];
  logic [8:0] tmp9;
  logic [7:0] bsel;

  function automatic logic [8:0] alu9(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      default: return 9'd0;
    endcase
  endfunction

  always_comb begin
    ALUOutputE = '0;
    ALUFlagsE  = '0;
    tmp9       = '0;
    bsel       = '0;
    for (int i = 0; i < 6; i++) begin
      case (VSIFlagE)
        2'b00:   bsel = b_lane[i];
        2'b01:   bsel = (SrcBiE < 4'd6) ? b_lane[SrcBiE[2:0]] : 8'd0;
        2'b10:   bsel = ImmE;
        default: bsel = 8'd0;
      endcase
      tmp9 = alu9(ALUControlE, a_lane[i], bsel);
      ALUOutputE[i*8 +: 8] = tmp9[7:0];
      ALUFlagsE[i*2 +: 2]  = {tmp9[8], tmp9[7:0] == 8'd0};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] pk(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                                     input logic [7:0] v3, input logic [7:0] v4, input logic [7:0] v5);
    return {v5, v4, v3, v2, v1, v0};
  endfunction

  task automatic push_exp(input logic [47:0] d, input logic [11:0] f, input logic [3:0] i,
                          input logic l, input logic e);
    beat_t b;
    b.d = d; b.f = f; b.i = i; b.l = l; b.e = e;
    exp_q.push_back(b);
  endtask

  task automatic set_b(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                       input logic [7:0] v3, input logic [7:0] v4, input logic [7:0] v5);
    b_lane[0] = v0; b_lane[1] = v1; b_lane[2] = v2;
    b_lane[3] = v3; b_lane[4] = v4; b_lane[5] = v5;
  endtask

  // Waits (bounded) for IDLE, presents one command, and drops valid just after the accept edge.
  task automatic send(input logic [2:0] op, input logic [1:0] mode, input logic [3:0] idx, input logic [7:0] imm);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_accept", 64'(req_ready), 64'(1));
    req_op = op; req_mode = mode; req_idx = idx; req_imm = imm;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic push_sweep(input int nbeats);
    logic [47:0] d;
    for (int k = 0; k < nbeats; k++) begin
      d = '0;
      for (int i = 0; i < 6; i++) d[i*8 +: 8] = 8'(i + 1 + 10 * (k + 1));
      push_exp(d, 12'h000, 4'(k), k == 5, 1'b0);
    end
  endtask

  // Scoreboard monitor: every accepted result beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got idx=%0d data=0x%0h expected no beat", res_idx, res_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_data", 64'(res_data), 64'(mon_e.d));
        chk("beat_flags", 64'(res_flags), 64'(mon_e.f));
        chk("beat_idx_last_err", 64'({res_idx, res_last, res_err}), 64'({mon_e.i, mon_e.l, mon_e.e}));
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  int issues;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_mode = '0; req_idx = '0; req_imm = '0;
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) a_lane[i] = 8'(i + 1);
    set_b(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_alu_issue", 64'(alu_issue), 64'(0));
    chk("rst_res_fields", 64'({res_data, res_flags, res_idx, res_last, res_err}), 64'(0));
    rst_n = 1'b1;

    // Vector-vector ADD: one beat, two edges after accept.
    res_ready = 1'b1;
    push_exp(pk(8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66), 12'h000, 4'd0, 1'b1, 1'b0);
    send(3'd0, 2'd0, 4'd0, 8'd0);
    @(negedge clk);
    chk("vv_issue_on", 64'(alu_issue), 64'(1));
    chk("vv_vsi", 64'(VSIFlagE), 64'(0));
    chk("vv_not_valid_yet", 64'(res_valid), 64'(0));
    @(negedge clk);
    chk("vv_res_valid", 64'(res_valid), 64'(1));
    chk("vv_issue_off", 64'(alu_issue), 64'(0));
    @(negedge clk);
    chk("vv_back_idle", 64'({req_ready, res_valid}), 64'(2'b10));

    // Vector-vector SUB to zero: zero flag on every lane.
    set_b(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
    push_exp(48'd0, 12'h555, 4'd0, 1'b1, 1'b0);
    send(3'd1, 2'd0, 4'd0, 8'd0);
    @(negedge clk);
    chk("sub_ctl", 64'(ALUControlE), 64'(1));
    repeat (2) @(negedge clk);

    // Vector-element idx 3.
    set_b(8'd10, 8'd20, 8'd30, 8'd7, 8'd50, 8'd60);
    push_exp(pk(8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13), 12'h000, 4'd3, 1'b1, 1'b0);
    send(3'd0, 2'd1, 4'd3, 8'd0);
    @(negedge clk);
    chk("ve_srcbi", 64'(SrcBiE), 64'(3));
    chk("ve_vsi", 64'(VSIFlagE), 64'(1));
    repeat (2) @(negedge clk);

    // Vector-element at the last legal index with carries.
    set_b(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd251);
    push_exp(pk(8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1), 12'hB00, 4'd5, 1'b1, 1'b0);
    send(3'd0, 2'd1, 4'd5, 8'd0);
    @(negedge clk);
    chk("ve5_srcbi", 64'(SrcBiE), 64'(5));
    repeat (2) @(negedge clk);

    // Out-of-range element: error beat without ALU issue.
    push_exp(48'd0, 12'h000, 4'd9, 1'b1, 1'b1);
    send(3'd2, 2'd1, 4'd9, 8'd0);
    @(negedge clk);
    chk("err_no_issue", 64'(alu_issue), 64'(0));
    chk("err_valid", 64'(res_valid), 64'(1));
    @(negedge clk);
    chk("err_back_idle", 64'(req_ready), 64'(1));

    // Sweep with res_ready held high: 6 beats, 12 cycles busy.
    set_b(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60);
    push_sweep(6);
    send(3'd0, 2'd3, 4'd0, 8'd0);
    issues = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("sweep_req_ready_low", 64'(req_ready), 64'(0));
      if (alu_issue) begin
        chk("sweep_srcbi", 64'(SrcBiE), 64'(issues));
        chk("sweep_vsi", 64'(VSIFlagE), 64'(1));
        issues++;
      end
    end
    @(negedge clk);
    chk("sweep_idle_after_12", 64'(req_ready), 64'(1));
    chk("sweep_issue_count", 64'(issues), 64'(6));

    // Immediate with a 4-cycle stall; a stray request during the stall is ignored.
    res_ready = 1'b0;
    push_exp(pk(8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11), 12'h000, 4'd0, 1'b1, 1'b0);
    send(3'd0, 2'd2, 4'd0, 8'd5);
    @(negedge clk);
    chk("vi_vsi", 64'(VSIFlagE), 64'(2));
    chk("vi_imm", 64'(ImmE), 64'(5));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_valid", 64'(res_valid), 64'(1));
      chk("stall_data", 64'(res_data), 64'(pk(8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11)));
      chk("stall_req_ready", 64'(req_ready), 64'(0));
      chk("stall_alu_quiet", 64'({alu_issue, ImmE}), 64'(0));
      if (c == 0) begin
        req_op = 3'd1; req_mode = 2'd0; req_idx = 4'd0; req_imm = 8'd0;
        req_valid = 1'b1;
      end
      if (c == 3) req_valid = 1'b0;
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", 64'(res_valid), 64'(1));
    @(negedge clk);
    chk("stall_retired", 64'({req_ready, res_valid}), 64'(2'b10));

    // Reset during the third sweep beat abandons the command.
    push_sweep(2);
    send(3'd0, 2'd3, 4'd0, 8'd0);
    repeat (5) @(negedge clk);
    res_ready = 1'b0;
    @(negedge clk);
    chk("rst3_beat_present", 64'({res_valid, res_idx}), 64'({1'b1, 4'd2}));
    rst_n = 1'b0;
    #1;
    chk("rst3_outputs", 64'({res_valid, req_ready, alu_issue, res_idx, res_last, res_err}),
        64'({1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}));
    chk("rst3_data", 64'({res_data, res_flags}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rst3_no_beat", 64'(res_valid), 64'(0));
    end
    push_exp(pk(8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66), 12'h000, 4'd0, 1'b1, 1'b0);
    send(3'd0, 2'd0, 4'd0, 8'd0);
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_op_sequencer.md
Name: lane_op_sequencer

Overview:
- Issue controller in front of the 6-lane vector ALU array.
- Accepts one vector-op command per valid/ready handshake and drives the array's control inputs: ALUControlE, VSIFlagE, SrcBiE, ImmE.
- Captures the six lane results and flag pairs into a result register and returns them over a valid/ready result channel.
- Sweep mode re-issues one command six times, broadcasting element 0..5 of B, producing six result beats.

Parameters:
N, 8, lane data width (must match the ALU array)
LANES, 6, lane count; fixed, defines sweep length

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  command accepted when both high
req_op  in  3  ALU operation code
req_mode  in  2  00 vec-vec, 01 vec-element, 10 vec-imm, 11 sweep
req_idx  in  4  element index for mode 01
req_imm  in  N  immediate for mode 10
ALUControlE  out  3  to ALU array
VSIFlagE  out  2  to ALU array B-mux select
SrcBiE  out  4  to ALU array element select
ImmE  out  N  to ALU array
alu_issue  out  1  high during the ALU evaluation cycle
ALUOutputE  in  6*N  lane results, lane 0 in the LSBs
ALUFlagsE  in  12  lane flag pairs, lane 0 in the LSBs
res_valid  out  1  result beat valid
res_ready  in  1  consumer accepts beat
res_data  out  6*N  captured lane results
res_flags  out  12  captured lane flags
res_idx  out  4  element index used for this beat
res_last  out  1  final beat of the command
res_err  out  1  command rejected

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, step=0, command register cleared.
  - All outputs 0 except req_ready=1.
  - Reset mid-command abandons it; no beat is produced after release.
- FSM states: IDLE, ISSUE, OUT.
- IDLE:
  - req_ready=1.
  - On req_valid: latch op/mode/idx/imm and set step=0.
  - If mode=01 and idx>5: go to OUT with res_err=1, res_data=0, res_flags=0, res_last=1, res_idx=idx. No ALU issue.
  - Otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - alu_issue=1; ALUControlE=op.
  - VSIFlagE: mode 00→00, 01→01, 10→10, 11→01.
  - SrcBiE: idx for mode 01, step for mode 11, 0 otherwise.
  - ImmE=imm for mode 10, 0 otherwise.
  - At the clock edge: capture ALUOutputE and ALUFlagsE into res_data and res_flags; res_idx = value driven on SrcBiE; res_last = (mode≠11) or (step=5); res_err=0. Go to OUT.
- ALU-facing outputs in IDLE and OUT: ALUControlE=0, VSIFlagE=0, SrcBiE=0, ImmE=0, alu_issue=0.
- OUT:
  - res_valid=1; all res_* outputs held stable until res_ready.
  - On res_ready with res_last=0: step++, go to ISSUE.
  - On res_ready with res_last=1: go to IDLE.
  - req_ready=0 throughout.
- Latency: request accept edge → res_valid after 2 edges.
- Sweep: 6 beats with res_idx 0..5 in order; each beat costs 2 cycles minimum.
- Throughput: one beat per 2 cycles when res_ready is held high.
- A new request is not accepted in the same cycle the last beat retires; the next acceptance is one cycle later, from IDLE.
- req_valid is ignored outside IDLE.
- Back-pressure of any length is tolerated; no beat is lost or duplicated.
- step saturates at 5 and resets to 0 on every acceptance.

Decomposition:
- Package lane_seq_pkg:
  - state enum {IDLE, ISSUE, OUT}.
  - mode constants MODE_VV, MODE_VE, MODE_VI, MODE_SWEEP.
  - VSI select constants VSI_VEC=00, VSI_ELEM=01, VSI_IMM=10.
  - LANES=6, LAST_IDX=5.
- One natural sub-module: lane_seq_result_reg. Holds the captured data, flags, idx, last and err, with load and clear controls.

Test Plan:
- Mode 00, op=ADD, A lanes=1..6, B lanes=10..60 → one beat two cycles after accept: res_data=11,22,33,44,55,66; res_last=1; alu_issue high exactly 1 cycle.
- Mode 01, idx=3, B[3]=7, A lanes=1..6 → SrcBiE=3 and VSIFlagE=01 during ISSUE; res_data=8..13; res_idx=3.
- Mode 01, idx=9 → no alu_issue; single beat with res_err=1, res_data=0, res_last=1.
- Mode 11, res_ready held high → 6 beats, res_idx 0..5, res_last only on beat 6; 12 cycles from accept to return to IDLE; req_ready=0 throughout.
- Mode 10, imm=0x05, res_ready low for 4 cycles → res_valid and res_data stable for all 4 cycles; beat retires on the first ready cycle; req_ready=0 during the stall.
- rst_n pulsed low during sweep beat 3 → all outputs return to reset values immediately; no further beats; next command accepted normally.
